spi_flash_responder: RTL and testbench

- SPI mode-0 target that emulates the serial-flash subset issued by the tinyfpga_bootloader SPI master: 0x9F JEDEC ID, 0x05 status, 0x03 read, 0xAB wake.
- Used on test and bring-up builds in place of physical flash. Read data comes from a byte-wide memory port, typically a BRAM image.
- All SPI inputs are oversampled in the clk_48mhz domain; there is no second clock.

---
 rtl/spi_flash_responder_if.sv | 26 ++
 rtl/spi_flash_responder.sv | 158 +++++++++++++++
 tb/tb_spi_flash_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_responder_if.sv
// rtl/spi_flash_responder_if.sv - SPI pins, memory read port and status for the flash responder.
interface spi_flash_responder_if #(
  parameter int ADDR_W = 24
);
  logic              spi_cs;
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              cmd_strobe;
  logic [7:0]        last_cmd;
  logic              busy;

  modport slave (
    input  spi_cs, spi_sck, spi_mosi, mem_rdata,
    output spi_miso, spi_miso_oe, mem_addr, mem_rd, cmd_strobe, last_cmd, busy
  );

  modport master (
    output spi_cs, spi_sck, spi_mosi, mem_rdata,
    input  spi_miso, spi_miso_oe, mem_addr, mem_rd, cmd_strobe, last_cmd, busy
  );
endinterface

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 serial-flash emulator (9F/05/03/AB) oversampled in clk_48mhz.
module spi_flash_responder #(
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
  parameter logic [7:0]  STATUS_VAL = 8'h00,
  parameter int          ADDR_W     = 24
) (
  input logic                  clk_48mhz,
  input logic                  reset,
  spi_flash_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE} state_t;

  state_t            state;
  logic [1:0]        cs_sync, sck_sync, mosi_sync, sync_ok;
  logic              cs_prev, sck_prev;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_shift, tx_shift;
  logic [7:0]        next_tx_byte;
  logic [1:0]        byte_idx, id_idx;
  logic [ADDR_W-1:0] addr;
  logic              rd_pending;

  logic              cs_s, cs_fall, sck_rise, sck_fall, byte_done;
  logic [7:0]        rx_byte;

  assign cs_s      = cs_sync[1];
  assign cs_fall   = cs_prev & ~cs_s;
  assign sck_rise  = sck_sync[1] & ~sck_prev;
  assign sck_fall  = ~sck_sync[1] & sck_prev;
  assign rx_byte   = {rx_shift, mosi_sync[1]};
  assign byte_done = (state != IDLE) & ~cs_s & sck_rise & (bit_cnt == 3'd7);
  assign bus.busy  = bus.spi_miso_oe;

  // cs_prev only learns "high" from a real sample, so a transaction already
  // running when reset releases never looks like a CS falling edge.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      cs_sync   <= 2'b11;
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      sync_ok   <= 2'b00;
      cs_prev   <= 1'b0;
      sck_prev  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], bus.spi_cs};
      sck_sync  <= {sck_sync[0], bus.spi_sck};
      mosi_sync <= {mosi_sync[0], bus.spi_mosi};
      sync_ok   <= {sync_ok[0], 1'b1};
      cs_prev   <= cs_s & sync_ok[1];
      sck_prev  <= sck_sync[1];
    end
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      rx_shift        <= '0;
      tx_shift        <= '0;
      next_tx_byte    <= '0;
      byte_idx        <= '0;
      id_idx          <= '0;
      addr            <= '0;
      rd_pending      <= 1'b0;
      bus.spi_miso    <= 1'b0;
      bus.spi_miso_oe <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_rd      <= 1'b0;
      bus.cmd_strobe  <= 1'b0;
      bus.last_cmd    <= '0;
    end else begin
      bus.spi_miso_oe <= ~cs_s;
      bus.mem_rd      <= 1'b0;
      bus.cmd_strobe  <= 1'b0;
      rd_pending      <= bus.mem_rd;
      if (state != IDLE && cs_s) begin
        state        <= IDLE;
        bit_cnt      <= '0;
        rx_shift     <= '0;
        tx_shift     <= '0;
        next_tx_byte <= '0;
        bus.spi_miso <= 1'b0;
      end else if (state == IDLE) begin
        bus.spi_miso <= 1'b0;
        if (cs_fall) begin
          state        <= CMD;
          bit_cnt      <= '0;
          rx_shift     <= '0;
          tx_shift     <= '0;
          next_tx_byte <= '0;
        end
      end else begin
        if (sck_rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (sck_fall) begin
          if (bit_cnt == 3'd0) begin
            tx_shift     <= next_tx_byte[6:0];
            bus.spi_miso <= next_tx_byte[7];
          end else begin
            tx_shift     <= {tx_shift[5:0], 1'b0};
            bus.spi_miso <= tx_shift[6];
          end
        end
        case (state)
          CMD: if (byte_done) begin
            bus.cmd_strobe <= 1'b1;
            bus.last_cmd   <= rx_byte;
            case (rx_byte)
              8'h03: begin
                state    <= ADDR;
                byte_idx <= '0;
              end
              8'h9F: begin
                state        <= ID;
                id_idx       <= '0;
                next_tx_byte <= JEDEC_ID[23:16];
              end
              8'h05: begin
                state        <= STAT;
                next_tx_byte <= STATUS_VAL;
              end
              default: state <= IGNORE;
            endcase
          end
          ADDR: if (byte_done) begin
            addr <= {addr[ADDR_W-9:0], rx_byte};
            if (byte_idx == 2'd2) begin
              bus.mem_addr <= {addr[ADDR_W-9:0], rx_byte};
              bus.mem_rd   <= 1'b1;
              state        <= DATA;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
          DATA: begin
            if (rd_pending) next_tx_byte <= bus.mem_rdata;
            if (byte_done) begin
              addr         <= addr + 1'b1;
              bus.mem_addr <= addr + 1'b1;
              bus.mem_rd   <= 1'b1;
            end
          end
          ID: if (byte_done) begin
            if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
            case (id_idx)
              2'd0:    next_tx_byte <= JEDEC_ID[15:8];
              2'd1:    next_tx_byte <= JEDEC_ID[7:0];
              default: next_tx_byte <= 8'h00;
            endcase
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - directed table-driven bench for spi_flash_responder.
module tb_spi_flash_responder;
  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   n_cmd    = 0;
  int   n_rd     = 0;
  logic [23:0] rd_log [0:63];

  spi_flash_responder_if #(.ADDR_W(24)) bus ();

  spi_flash_responder #(.STATUS_VAL(8'h5A)) dut (
    .clk_48mhz(clk),
    .reset    (reset),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide memory image: data = addr[7:0] ^ A5, one cycle after the strobe.
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= bus.mem_addr[7:0] ^ 8'hA5;

  always @(negedge clk) begin
    if (bus.cmd_strobe) n_cmd++;
    if (bus.mem_rd) begin
      if (n_rd < 64) rd_log[n_rd] = bus.mem_addr;
      n_rd++;
    end
  end

  typedef struct packed {
    logic [7:0]        op;
    logic              is_read;
    logic [23:0]       start;
    int                nbytes;
    logic [0:3][7:0]   exp_miso;
    int                exp_reads;
    logic [0:3][23:0]  exp_addr;
  } vec_t;

  vec_t vecs [0:4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      bus.spi_mosi = tx[7-b];
      repeat (4) @(negedge clk);
      rx = {rx[6:0], bus.spi_miso};
      bus.spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.spi_cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    bus.spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_vec(input int v);
    int          c0, r0;
    logic [7:0]  got;
    logic [23:0] a;
    c0 = n_cmd;
    r0 = n_rd;
    a  = vecs[v].start;
    cs_low();
    check($sformatf("v%0d_oe_low", v), 32'(bus.spi_miso_oe), 32'd1);
    check($sformatf("v%0d_busy_low", v), 32'(bus.busy), 32'd1);
    xfer(vecs[v].op, 8, got);
    if (vecs[v].is_read)
      for (int k = 0; k < 3; k++) xfer(a[23-8*k -: 8], 8, got);
    for (int i = 0; i < vecs[v].nbytes; i++) begin
      xfer(8'h00, 8, got);
      check($sformatf("v%0d_miso%0d", v, i), 32'(got), 32'(vecs[v].exp_miso[i]));
    end
    cs_high();
    check($sformatf("v%0d_cmd_strobes", v), 32'(n_cmd - c0), 32'd1);
    check($sformatf("v%0d_last_cmd", v), 32'(bus.last_cmd), 32'(vecs[v].op));
    check($sformatf("v%0d_reads", v), 32'(n_rd - r0), 32'(vecs[v].exp_reads));
    for (int i = 0; i < vecs[v].exp_reads && i < 4; i++)
      check($sformatf("v%0d_addr%0d", v, i), 32'(rd_log[r0+i]), 32'(vecs[v].exp_addr[i]));
    check($sformatf("v%0d_oe_idle", v), 32'(bus.spi_miso_oe), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         c0, r0;
    logic [7:0] got;

    vecs[0] = '{op: 8'h9F, is_read: 1'b0, start: 24'h0, nbytes: 4,
                exp_miso: {8'hEF, 8'h40, 8'h16, 8'h00}, exp_reads: 0,
                exp_addr: {24'h0, 24'h0, 24'h0, 24'h0}};
    vecs[1] = '{op: 8'h05, is_read: 1'b0, start: 24'h0, nbytes: 3,
                exp_miso: {8'h5A, 8'h5A, 8'h5A, 8'h00}, exp_reads: 0,
                exp_addr: {24'h0, 24'h0, 24'h0, 24'h0}};
    vecs[2] = '{op: 8'h03, is_read: 1'b1, start: 24'h0001FE, nbytes: 3,
                exp_miso: {8'h5B, 8'h5A, 8'hA5, 8'h00}, exp_reads: 4,
                exp_addr: {24'h0001FE, 24'h0001FF, 24'h000200, 24'h000201}};
    vecs[3] = '{op: 8'h03, is_read: 1'b1, start: 24'hFFFFFF, nbytes: 2,
                exp_miso: {8'h5A, 8'hA5, 8'h00, 8'h00}, exp_reads: 3,
                exp_addr: {24'hFFFFFF, 24'h000000, 24'h000001, 24'h0}};
    vecs[4] = '{op: 8'hAB, is_read: 1'b0, start: 24'h0, nbytes: 2,
                exp_miso: {8'h00, 8'h00, 8'h00, 8'h00}, exp_reads: 0,
                exp_addr: {24'h0, 24'h0, 24'h0, 24'h0}};

    reset        = 1'b1;
    bus.spi_cs   = 1'b1;
    bus.spi_sck  = 1'b0;
    bus.spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(bus.spi_miso), 32'd0);
    check("rst_oe", 32'(bus.spi_miso_oe), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_cmd_strobe", 32'(bus.cmd_strobe), 32'd0);
    check("rst_last_cmd", 32'(bus.last_cmd), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_oe", 32'(bus.spi_miso_oe), 32'd0);

    for (int v = 0; v < 5; v++) run_vec(v);

    // Abort inside the second address byte, then a clean JEDEC ID.
    c0 = n_cmd;
    r0 = n_rd;
    cs_low();
    xfer(8'h03, 8, got);
    xfer(8'h00, 8, got);
    xfer(8'h12, 3, got);
    cs_high();
    check("abort_reads", 32'(n_rd - r0), 32'd0);
    check("abort_cmd_strobes", 32'(n_cmd - c0), 32'd1);
    check("abort_last_cmd", 32'(bus.last_cmd), 32'h03);
    check("abort_oe", 32'(bus.spi_miso_oe), 32'd0);
    run_vec(0);

    // Partial opcode: no strobe, last_cmd retained.
    c0 = n_cmd;
    cs_low();
    xfer(8'h05, 5, got);
    cs_high();
    check("partial_cmd_strobes", 32'(n_cmd - c0), 32'd0);
    check("partial_last_cmd", 32'(bus.last_cmd), 32'h9F);

    // Reset during DATA; the rest of that CS-low window must be ignored.
    cs_low();
    xfer(8'h03, 8, got);
    xfer(8'h00, 8, got);
    xfer(8'h00, 8, got);
    xfer(8'h10, 8, got);
    xfer(8'h00, 8, got);
    check("mid_read_byte", 32'(got), 32'hB5);
    xfer(8'h00, 3, got);
    reset = 1'b1;
    #1;
    check("mid_rst_miso", 32'(bus.spi_miso), 32'd0);
    check("mid_rst_oe", 32'(bus.spi_miso_oe), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("mid_rst_last_cmd", 32'(bus.last_cmd), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    c0 = n_cmd;
    r0 = n_rd;
    xfer(8'h9F, 8, got);
    xfer(8'h00, 8, got);
    check("post_rst_miso", 32'(got), 32'd0);
    cs_high();
    check("post_rst_cmd_strobes", 32'(n_cmd - c0), 32'd0);
    check("post_rst_reads", 32'(n_rd - r0), 32'd0);
    run_vec(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
